// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Shares one uart transmitter (din/wrn/send_over) between two byte
//            requesters on the clk1_8m domain. The arbiter grants requesters
//            round-robin, latches the granted byte onto din and launches it
//            with a one-cycle wrn pulse. It then follows send_over through
//            busy and done, and inserts an inter-byte gap. Watchdogs raise a
//            sticky err so that a stuck transmitter cannot lock out the
//            requesters.
// Options  : `define ARB_FIXED_PRIO_EN -> requester 0 always wins when both
//            requesters ask in the same cycle (no round-robin pointer).
// Ports    : clk, rst        clock, synchronous active-high reset
//            req0/data0/ack0 requester 0 handshake (ack = capture pulse)
//            req1/data1/ack1 requester 1 handshake
//            din, wrn        byte and one-cycle write strobe to the uart
//            send_over       uart idle level (1 = idle, 0 = shifting)
//            busy            high whenever the FSM is not in IDLE
//            grant_id        requester owning the current or last transfer
//            err, err_clr    sticky timeout flag and its clear
//            byte_cnt        bytes completed without timeout (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int GAP_CYC  = 4,
  parameter int BUSY_TMO = 64,
  parameter int DONE_TMO = 65535,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [7:0]       data0,
  output logic             ack0,
  input  logic             req1,
  input  logic [7:0]       data1,
  output logic             ack1,
  output logic [7:0]       din,
  output logic             wrn,
  input  logic             send_over,
  output logic             busy,
  output logic             grant_id,
  output logic             err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] byte_cnt
);

  // One shared cycle counter serves both watchdogs and the gap. GAP_CYC must
  // not exceed the larger timeout, and both timeouts must be at least 1.
  localparam int TMO_MAX = (BUSY_TMO > DONE_TMO) ? BUSY_TMO : DONE_TMO;
  localparam int TMO_W   = $clog2(TMO_MAX + 1);

  localparam logic [TMO_W-1:0] BUSY_LAST = TMO_W'(BUSY_TMO - 1);
  localparam logic [TMO_W-1:0] DONE_LAST = TMO_W'(DONE_TMO - 1);
  // GAP_CYC = 0 still spends one cycle in GAP.
  localparam logic [TMO_W-1:0] GAP_LAST  = (GAP_CYC > 0) ? TMO_W'(GAP_CYC - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_GRANT     = 3'd1,
    S_STROBE    = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_GAP       = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [TMO_W-1:0] tmo;       // cycles spent in the current state
  logic             sel;       // requester chosen at arbitration
  logic             win;       // arbitration result this cycle
  logic             timeout;   // watchdog expired this cycle
  logic             complete;  // byte finished normally this cycle

`ifdef ARB_FIXED_PRIO_EN
  // Requester 1 only wins when requester 0 is not asking.
  assign win = ~req0;
`else
  logic rr;  // requester preferred on the next simultaneous request
  assign win = (req0 & req1) ? rr : ~req0;
`endif

  // Next-state logic and Moore outputs
  always_comb begin
    state_nxt = state;
    timeout   = 1'b0;
    complete  = 1'b0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    wrn       = 1'b0;
    busy      = (state != S_IDLE);

    case (state)
      S_IDLE: begin
        // A busy uart blocks arbitration even with requests pending.
        if (send_over && (req0 || req1)) state_nxt = S_GRANT;
      end
      S_GRANT: begin
        ack0      = ~sel;
        ack1      = sel;
        state_nxt = S_STROBE;
      end
      S_STROBE: begin
        wrn       = 1'b1;
        state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!send_over) begin
          state_nxt = S_WAIT_DONE;
        end else if (tmo == BUSY_LAST) begin
          timeout   = 1'b1;
          state_nxt = S_GAP;
        end
      end
      S_WAIT_DONE: begin
        if (send_over) begin
          complete  = 1'b1;
          state_nxt = S_GAP;
        end else if (tmo == DONE_LAST) begin
          timeout   = 1'b1;
          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (tmo >= GAP_LAST) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register and datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tmo      <= '0;
      sel      <= 1'b0;
      din      <= 8'h00;
      grant_id <= 1'b0;
      err      <= 1'b0;
      byte_cnt <= '0;
`ifndef ARB_FIXED_PRIO_EN
      rr       <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      // Restart the counter on every state change; it only matters in the
      // wait and gap states, so wrapping while IDLE is harmless.
      tmo   <= (state_nxt != state) ? '0 : tmo + 1'b1;

      if (state == S_IDLE) sel <= win;

      if (state == S_GRANT) begin
        din      <= sel ? data1 : data0;
        grant_id <= sel;
`ifndef ARB_FIXED_PRIO_EN
        rr       <= ~sel;
`endif
      end

      // A timeout in the same cycle as err_clr keeps err set.
      if (timeout)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;

      if (complete) byte_cnt <= byte_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Self-checking bench for uart_tx_arbiter. It contains directed
//            corner-case sequences, a table of arbitration vectors and a
//            randomized run checked against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int GAP  = 4;
  localparam int GP   = (GAP == 0) ? 1 : GAP;  // cycles actually spent in GAP
  localparam int BTMO = 64;
  localparam int DTMO = 100;
  localparam int CW   = 3;                     // small counter so wrap is reachable
  localparam int BIG  = 1 << 30;
`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    rq;
  logic [7:0]    dt [0:1];
  logic          so;
  logic          err_clr;
  logic          ack0, ack1, wrn, busy, grant_id, err;
  logic [7:0]    din;
  logic [CW-1:0] byte_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic       r0;
    logic       r1;
    logic [7:0] d0;
    logic [7:0] d1;
    int         win_rr;
    int         win_fix;
    int         cnt;
  } vec_t;
  vec_t tbl [8];

  // random-phase model state
  int         m_rr, m_cnt, next_elig, wrn_due, fall_at, rise_at;
  int         k, pk, win, egid, w;
  int         tmr [2];
  logic [1:0] drop, pr, eack;
  logic [7:0] pd0, pd1, edin;
  logic       pso;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .GAP_CYC (GAP),
    .BUSY_TMO(BTMO),
    .DONE_TMO(DTMO),
    .CNT_W   (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (rq[0]),
    .data0    (dt[0]),
    .ack0     (ack0),
    .req1     (rq[1]),
    .data1    (dt[1]),
    .ack1     (ack1),
    .din      (din),
    .wrn      (wrn),
    .send_over(so),
    .busy     (busy),
    .grant_id (grant_id),
    .err      (err),
    .err_clr  (err_clr),
    .byte_cnt (byte_cnt)
  );

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!(ack0 | ack1) && n < 60);
    chk("ack_seen", 32'(ack0 | ack1), 1);
  endtask

  // Called on the cycle wrn is seen: uart drops send_over after d1 cycles,
  // keeps it low d2 cycles, then returns idle. Returns one cycle after the
  // rising level has been sampled.
  task automatic uart_serve(input int d1, input int d2);
    repeat (d1) step();
    so = 1'b0;
    repeat (d2) step();
    so = 1'b1;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1; rq = 2'b00; so = 1'b1; err_clr = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 1'b1, 8'h11, 8'h22, 0, 0, 1};
    tbl[1] = '{1'b1, 1'b1, 8'h23, 8'h34, 1, 0, 2};
    tbl[2] = '{1'b1, 1'b0, 8'h45, 8'h00, 0, 0, 3};
    tbl[3] = '{1'b1, 1'b0, 8'h56, 8'h00, 0, 0, 4};
    tbl[4] = '{1'b1, 1'b1, 8'h67, 8'h78, 1, 0, 5};
    tbl[5] = '{1'b0, 1'b1, 8'h00, 8'h89, 1, 1, 6};
    tbl[6] = '{1'b1, 1'b1, 8'h9A, 8'hAB, 0, 0, 7};
    tbl[7] = '{1'b0, 1'b1, 8'h00, 8'hBC, 1, 1, 0};

    // ---- reset with a request held, then first transfer ----
    rst = 1'b1; rq = 2'b01; dt[0] = 8'hA5; dt[1] = 8'h00; so = 1'b1; err_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_ack0", ack0, 0);
      chk("rst_wrn", wrn, 0);
    end
    chk("rst_ack1", ack1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_din", din, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", byte_cnt, 0);
    rst = 1'b0;
    step();
    chk("a_ack0", ack0, 1);
    chk("a_wrn_early", wrn, 0);
    step();
    chk("a_wrn", wrn, 1);
    chk("a_din", din, 8'hA5);
    chk("a_ack0_once", ack0, 0);
    rq[0] = 1'b0;
    uart_serve(1, 10);
    chk("a_cnt", byte_cnt, 1);
    chk("a_gid", grant_id, 0);

    // ---- both requesters held continuously ----
    do_reset();
    rq = 2'b11; dt[0] = 8'h11; dt[1] = 8'h22;
    for (int i = 0; i < 4; i++) begin
      int ewin;
      wait_ack(w);
      ewin = FIXED ? 0 : (i % 2);
      if (i > 0) chk("b_gap", w, GP + 1);
      chk("b_ack", {ack1, ack0}, (ewin == 1) ? 2 : 1);
      step();
      chk("b_wrn", wrn, 1);
      chk("b_din", din, (ewin == 1) ? 8'h22 : 8'h11);
      chk("b_gid", grant_id, ewin);
      uart_serve(1, 3);
    end
    rq = 2'b00;
    chk("b_cnt", byte_cnt, 4);

    // ---- send_over never falls: busy timeout ----
    rq = 2'b01; dt[0] = 8'h5A;
    wait_ack(w);
    chk("c_ack", ack0, 1);
    step();
    chk("c_wrn", wrn, 1);
    rq = 2'b00;
    repeat (BTMO) step();
    chk("c_err_pre", err, 0);
    step();
    chk("c_err", err, 1);
    chk("c_busy", busy, 1);
    repeat (GP - 1) step();
    chk("c_gap_busy", busy, 1);
    step();
    chk("c_idle", busy, 0);
    chk("c_cnt", byte_cnt, 4);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("c_clr", err, 0);

    // ---- send_over stuck low: done timeout, set beats clear ----
    rq = 2'b10; dt[1] = 8'hC3;
    wait_ack(w);
    chk("d_ack", ack1, 1);
    step();
    chk("d_wrn", wrn, 1);
    chk("d_din", din, 8'hC3);
    rq = 2'b00;
    step();
    so = 1'b0;
    repeat (DTMO) step();
    chk("d_err_pre", err, 0);
    err_clr = 1'b1;
    step();
    chk("d_err", err, 1);
    err_clr = 1'b0;
    so = 1'b1;
    chk("d_cnt", byte_cnt, 4);
    rq = 2'b01; dt[0] = 8'h3C;
    wait_ack(w);
    step();
    chk("d2_wrn", wrn, 1);
    chk("d2_din", din, 8'h3C);
    rq = 2'b00;
    uart_serve(2, 5);
    chk("d2_cnt", byte_cnt, 5);

    // ---- reset during WAIT_DONE ----
    rq = 2'b01; dt[0] = 8'h77;
    wait_ack(w);
    step();
    rq = 2'b00;
    chk("e_wrn", wrn, 1);
    step();
    so = 1'b0;
    step();
    step();
    chk("e_busy_pre", busy, 1);
    chk("e_err_pre", err, 1);
    chk("e_cnt_pre", byte_cnt, 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("e_busy", busy, 0);
    chk("e_err", err, 0);
    chk("e_cnt", byte_cnt, 0);
    chk("e_din", din, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("e_no_wrn", wrn, 0);
    end
    so = 1'b1;

    // ---- table of arbitration vectors (counter wraps at the end) ----
    for (int i = 0; i < 8; i++) begin
      int ewin;
      rq = {tbl[i].r1, tbl[i].r0};
      dt[0] = tbl[i].d0;
      dt[1] = tbl[i].d1;
      ewin = FIXED ? tbl[i].win_fix : tbl[i].win_rr;
      wait_ack(w);
      chk("t_ack", {ack1, ack0}, (ewin == 1) ? 2 : 1);
      step();
      chk("t_wrn", wrn, 1);
      chk("t_din", din, (ewin == 1) ? tbl[i].d1 : tbl[i].d0);
      chk("t_gid", grant_id, ewin);
      rq = 2'b00;
      uart_serve(1, 2);
      chk("t_cnt", byte_cnt, tbl[i].cnt);
    end

    // ---- randomized traffic against a transaction-level model ----
    do_reset();
    m_rr = 0; m_cnt = 0; next_elig = cyc; wrn_due = -1; fall_at = -1; rise_at = -1;
    drop = 2'b00; tmr[0] = 0; tmr[1] = 0; edin = 8'h00; egid = 0;
    pr = rq; pd0 = dt[0]; pd1 = dt[1]; pso = so; pk = cyc;
    for (int it = 0; it < 2500; it++) begin
      step();
      k = cyc;
      eack = 2'b00;
      // inputs driven last cycle were sampled by an idle arbiter?
      if (pk >= next_elig && pso && pr != 2'b00) begin
        if (pr == 2'b11) win = FIXED ? 0 : m_rr;
        else             win = pr[0] ? 0 : 1;
        eack      = (win == 1) ? 2'b10 : 2'b01;
        m_rr      = 1 - win;
        edin      = (win == 1) ? pd1 : pd0;
        egid      = win;
        wrn_due   = k + 1;
        next_elig = BIG;
      end
      chk("r_ack", {ack1, ack0}, eack);
      chk("r_wrn", wrn, 32'(k == wrn_due));
      if (k == wrn_due) begin
        chk("r_din", din, edin);
        chk("r_gid", grant_id, egid);
        fall_at = k + $urandom_range(1, 4);
        rise_at = fall_at + $urandom_range(1, 10);
      end
      if (k == rise_at + 1) m_cnt = (m_cnt + 1) % (1 << CW);
      chk("r_cnt", byte_cnt, m_cnt);
      chk("r_busy", busy, 32'(k < next_elig));
      chk("r_err", err, 0);
      // uart response
      if (k == fall_at) so = 1'b0;
      if (k == rise_at) begin
        so        = 1'b1;
        next_elig = k + 1 + GP;
      end
      // requesters: hold through the ack cycle, drop next, re-arm later
      for (int n = 0; n < 2; n++) begin
        if ((n == 0 && ack0) || (n == 1 && ack1)) begin
          drop[n] = 1'b1;
        end else if (drop[n]) begin
          rq[n]   = 1'b0;
          drop[n] = 1'b0;
          tmr[n]  = $urandom_range(0, 6);
        end else if (!rq[n]) begin
          if (tmr[n] == 0) begin
            rq[n] = 1'b1;
            dt[n] = 8'($urandom);
          end else begin
            tmr[n]--;
          end
        end
      end
      pr = rq; pd0 = dt[0]; pd1 = dt[1]; pso = so; pk = k;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
